// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: load/store opcodes,
// FSM state encoding and per-size byte-count constants.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  localparam logic WRITE_DISABLE = 1'b0;

  // Load/store opcodes carried on load_store_type
  localparam logic [TYPE_W-1:0] EXE_LB  = 4'd0;
  localparam logic [TYPE_W-1:0] EXE_LH  = 4'd1;
  localparam logic [TYPE_W-1:0] EXE_LW  = 4'd2;
  localparam logic [TYPE_W-1:0] EXE_LBU = 4'd3;
  localparam logic [TYPE_W-1:0] EXE_LHU = 4'd4;
  localparam logic [TYPE_W-1:0] EXE_SB  = 4'd5;
  localparam logic [TYPE_W-1:0] EXE_SH  = 4'd6;
  localparam logic [TYPE_W-1:0] EXE_SW  = 4'd7;

  // Byte-count constants expressed as the index of the final byte (N-1)
  localparam logic [CNT_W-1:0] LAST_IDX_B = 2'd0;
  localparam logic [CNT_W-1:0] LAST_IDX_H = 2'd1;
  localparam logic [CNT_W-1:0] LAST_IDX_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LAST   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Index of the final byte for an access of the given type
  function automatic logic [CNT_W-1:0] last_idx(input logic [TYPE_W-1:0] t);
    case (t)
      EXE_LB, EXE_LBU, EXE_SB: last_idx = LAST_IDX_B;
      EXE_LH, EXE_LHU, EXE_SH: last_idx = LAST_IDX_H;
      default:                 last_idx = LAST_IDX_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load result extension: turns the captured little-endian word into the
// 32-bit register value according to the load type.
//   word_i : bytes captured from RAM (byte 0 in bits 7:0)
//   type_i : load opcode
//   data_o : sign/zero-extended (or raw for LW) result
module mem_access_load_extend
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [TYPE_W-1:0] type_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = word_i;
    case (type_i)
      EXE_LB:  data_o = {{24{word_i[7]}}, word_i[7:0]};
      EXE_LH:  data_o = {{16{word_i[15]}}, word_i[15:0]};
      EXE_LBU: data_o = {24'd0, word_i[7:0]};
      EXE_LHU: data_o = {16'd0, word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage with a byte-wide RAM port. Loads and stores are serialised into
// single-byte RAM accesses while the upstream pipeline is stalled.
//   clk, rst                         : clock, async active-high reset
//   rd_data_i/rd_addr_i/rd_enable_i  : EX/MEM writeback payload
//   load_enable/store_enable         : access requests (both high = store)
//   mem_addr/store_data/load_store_type : access address, data, opcode
//   ram_addr/ram_wr/ram_din/ram_dout : byte RAM port (1-cycle read latency)
//   rd_data_o/rd_addr_o/rd_enable_o  : MEM/WB payload
//   stall_req                        : freezes PC and upstream registers
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [REG_W-1:0]  rd_addr_i,
  input  logic              rd_enable_i,
  input  logic              load_enable,
  input  logic              store_enable,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [TYPE_W-1:0] load_store_type,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [BYTE_W-1:0] ram_din,
  input  logic [BYTE_W-1:0] ram_dout,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [REG_W-1:0]  rd_addr_o,
  output logic              rd_enable_o,
  output logic              stall_req
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic                store_q, store_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [REG_W-1:0]    raddr_q, raddr_d;
  logic                ren_q, ren_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   load_ext;

  mem_access_load_extend u_load_extend (
    .word_i (word_q),
    .type_i (type_q),
    .data_o (load_ext)
  );

  // State and access latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      type_q  <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      type_q  <= type_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      ren_q   <= ren_d;
      word_q  <= word_d;
    end
  end

  // Next state, byte sequencing and stage outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    type_d      = type_q;
    store_d     = store_q;
    rdata_d     = rdata_q;
    raddr_d     = raddr_q;
    ren_d       = ren_q;
    word_d      = word_q;
    ram_addr    = '0;
    ram_wr      = 1'b0;
    ram_din     = '0;
    stall_req   = 1'b0;
    rd_data_o   = '0;
    rd_addr_o   = '0;
    rd_enable_o = WRITE_DISABLE;

    case (state_q)
      IDLE: begin
        rd_data_o   = rd_data_i;
        rd_addr_o   = rd_addr_i;
        rd_enable_o = rd_enable_i;
        if (load_enable || store_enable) begin
          stall_req   = 1'b1;
          rd_enable_o = WRITE_DISABLE;
          state_d     = ACCESS;
          cnt_d       = '0;
          addr_d      = mem_addr;
          sdata_d     = store_data;
          type_d      = load_store_type;
          store_d     = store_enable;
          rdata_d     = rd_data_i;
          raddr_d     = rd_addr_i;
          ren_d       = rd_enable_i;
        end
      end
      ACCESS: begin
        stall_req = 1'b1;
        ram_addr  = addr_q + ADDR_W'(cnt_q);
        cnt_d     = cnt_q + 2'd1;
        if (store_q) begin
          ram_wr  = 1'b1;
          ram_din = BYTE_W'(sdata_q >> {cnt_q, 3'b000});
        end else if (cnt_q != '0) begin
          // RAM returns the byte addressed one cycle earlier
          word_d[{cnt_q - 2'd1, 3'b000} +: BYTE_W] = ram_dout;
        end
        if (cnt_q == last_idx(type_q)) begin
          state_d = store_q ? DONE : LAST;
        end
      end
      LAST: begin
        stall_req = 1'b1;
        // cnt has advanced to N (mod 4), so N-1 names the final byte
        word_d[{cnt_q - 2'd1, 3'b000} +: BYTE_W] = ram_dout;
        state_d = DONE;
      end
      DONE: begin
        rd_data_o   = store_q ? rdata_q : load_ext;
        rd_addr_o   = raddr_q;
        rd_enable_o = ren_q;
        cnt_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are quiet for as long as reset is held
    if (rst) begin
      ram_addr    = '0;
      ram_wr      = 1'b0;
      ram_din     = '0;
      stall_req   = 1'b0;
      rd_data_o   = '0;
      rd_addr_o   = '0;
      rd_enable_o = WRITE_DISABLE;
    end
  end

endmodule
